// File: rtl/ts_null_stuffer.sv
// rtl/ts_null_stuffer.sv - constant-rate TS byte output with null-packet stuffing
// Passes whole packets from a show-ahead FIFO, otherwise emits null packets; drops misaligned bytes.
module ts_null_stuffer #(
  parameter int          PKT_LEN  = 188,
  parameter int          USEDW_W  = 10,
  parameter logic [12:0] NULL_PID = 13'h1FFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         data_in,
  input  logic               p_sync_in,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  output logic               rd_req,
  output logic [7:0]         data_out,
  output logic               d_valid_out,
  output logic               p_sync_out,
  output logic [15:0]        null_cnt,
  output logic [15:0]        drop_cnt,
  output logic               uflow
);

  localparam int BC_W = $clog2(PKT_LEN);

  typedef enum logic [1:0] {ST_START, ST_PASS, ST_NULL} state_t;

  state_t             state, state_nxt;
  logic [BC_W-1:0]    bc, bc_nxt;
  logic               starve;
  logic               last, head_ok, abort, in_null, go_pass, uflow_nxt;
  logic [USEDW_W-1:0] avail;
  logic [7:0]         null_byte, data_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_START;
      bc    <= '0;
    end else begin
      state <= state_nxt;
      bc    <= bc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bc_nxt    = bc;
    case (state)
      ST_START: begin
        state_nxt = go_pass ? ST_PASS : ST_NULL;
        bc_nxt    = '0;
      end
      default: begin
        bc_nxt = last ? '0 : bc + BC_W'(1);
        if (last)
          state_nxt = go_pass ? ST_PASS : ST_NULL;
        else if (abort)
          state_nxt = ST_NULL;
      end
    endcase
  end

  always_comb begin
    last    = (bc == BC_W'(PKT_LEN - 1));
    head_ok = !fifo_empty && p_sync_in;
    // A passed packet that does not start on a sync byte becomes a null packet in place.
    abort   = (state == ST_PASS) && (bc == '0) && !head_ok;
    in_null = (state == ST_NULL) || abort;
    case (state)
      ST_PASS: rd_req = !abort && !starve && !fifo_empty;
      ST_NULL: rd_req = !fifo_empty && !p_sync_in;
      default: rd_req = 1'b0;
    endcase
    // When popping at the boundary the new head is unseen; its sync is checked at bc 0 instead.
    avail     = fifo_usedw - USEDW_W'(rd_req);
    go_pass   = (avail >= USEDW_W'(PKT_LEN)) && (rd_req || head_ok);
    uflow_nxt = (state == ST_PASS) && !abort && !starve && fifo_empty;
    case (bc)
      BC_W'(0): null_byte = 8'h47;
      BC_W'(1): null_byte = {3'b000, NULL_PID[12:8]};
      BC_W'(2): null_byte = NULL_PID[7:0];
      BC_W'(3): null_byte = 8'h10;
      default:  null_byte = 8'hFF;
    endcase
    if (state == ST_START)
      data_nxt = 8'h00;
    else if (in_null)
      data_nxt = null_byte;
    else if (starve || fifo_empty)
      data_nxt = 8'hFF;
    else
      data_nxt = data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= 8'h00;
      d_valid_out <= 1'b0;
      p_sync_out  <= 1'b0;
      uflow       <= 1'b0;
      starve      <= 1'b0;
      null_cnt    <= 16'h0000;
      drop_cnt    <= 16'h0000;
    end else begin
      data_out    <= data_nxt;
      d_valid_out <= (state != ST_START);
      p_sync_out  <= (state != ST_START) && (bc == '0);
      uflow       <= uflow_nxt;
      starve      <= !last && (starve || uflow_nxt);
      if (in_null && (bc == '0) && (null_cnt != 16'hFFFF))
        null_cnt <= null_cnt + 16'd1;
      if ((state == ST_NULL) && rd_req && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ts_null_stuffer.sv
// tb/tb_ts_null_stuffer.sv - directed bench for ts_null_stuffer
// Models a show-ahead FIFO and checks the output byte stream against hand-built packets.
module tb_ts_null_stuffer;

  localparam int PKT_LEN = 188;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic [7:0]  data_in    = 8'h00;
  logic        p_sync_in  = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [9:0]  fifo_usedw = 10'd0;
  logic        rd_req;
  logic [7:0]  data_out;
  logic        d_valid_out;
  logic        p_sync_out;
  logic [15:0] null_cnt;
  logic [15:0] drop_cnt;
  logic        uflow;

  logic [7:0] src_d [0:1023];
  logic       src_s [0:1023];
  int   ld       = 0;
  int   wr_ptr   = 0;
  int   rd_ptr   = 0;
  logic hold     = 1'b0;
  logic rd_s     = 1'b0;
  int   bad_pop  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  ts_null_stuffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .p_sync_in  (p_sync_in),
    .fifo_empty (fifo_empty),
    .fifo_usedw (fifo_usedw),
    .rd_req     (rd_req),
    .data_out   (data_out),
    .d_valid_out(d_valid_out),
    .p_sync_out (p_sync_out),
    .null_cnt   (null_cnt),
    .drop_cnt   (drop_cnt),
    .uflow      (uflow)
  );

  always #5 clk = ~clk;

  task automatic drive_fifo();
    int n;
    n = hold ? 0 : wr_ptr - rd_ptr;
    fifo_empty = (n <= 0);
    fifo_usedw = (n > 0) ? 10'(n) : 10'd0;
    data_in    = (n > 0) ? src_d[rd_ptr] : 8'h00;
    p_sync_in  = (n > 0) ? src_s[rd_ptr] : 1'b0;
  endtask

  // FIFO inputs change only just after clock edges; the pop request is captured before the edge.
  always begin
    @(negedge clk);
    #1 drive_fifo();
    #3 rd_s = rd_req;
    @(posedge clk);
    if (!rst_n)
      rd_ptr = 0;
    else if (rd_s) begin
      if (fifo_empty) bad_pop++;
      else rd_ptr++;
    end
    #1 drive_fifo();
  end

  function automatic logic [7:0] pkt_byte(input logic [7:0] base, input int k);
    return (k == 0) ? 8'h47 : 8'(base + 8'(k));
  endfunction

  function automatic logic [7:0] exp_null(input int k);
    case (k)
      0:       return 8'h47;
      1:       return 8'h1F;
      2:       return 8'hFF;
      3:       return 8'h10;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic put_pkt(input logic [7:0] base, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      src_d[ld] = pkt_byte(base, k);
      src_s[ld] = (k == 0);
      ld++;
    end
  endtask

  task automatic put_stray(input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      src_d[ld] = 8'hA0 + 8'(k);
      src_s[ld] = 1'b0;
      ld++;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    hold   = 1'b0;
    ld     = 0;
    wr_ptr = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (d_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL start_cycle_valid: got %b expected 0", d_valid_out);
    end
  endtask

  task automatic test_reset();
    do_reset();
    put_pkt(8'h00, PKT_LEN);
    wr_ptr = ld;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({data_out, d_valid_out, p_sync_out, uflow, rd_req, null_cnt, drop_cnt} !== 45'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h valid=%b sync=%b uflow=%b rd=%b null=%h drop=%h expected all 0",
               data_out, d_valid_out, p_sync_out, uflow, rd_req, null_cnt, drop_cnt);
    end
  endtask

  task automatic test_empty_nulls();
    int k;
    bit rd_seen;
    do_reset();
    release_reset();
    rd_seen = 1'b0;
    for (int c = 2; c < 2 + 3 * PKT_LEN; c++) begin
      @(negedge clk);
      k = (c - 2) % PKT_LEN;
      n_checks++;
      if (data_out !== exp_null(k) || d_valid_out !== 1'b1 || p_sync_out !== (k == 0)) begin
        n_fail++;
        $display("FAIL null_stream c=%0d: got data=%h valid=%b sync=%b expected data=%h valid=1 sync=%b",
                 c, data_out, d_valid_out, p_sync_out, exp_null(k), (k == 0));
      end
      if (rd_req) rd_seen = 1'b1;
    end
    n_checks++;
    if (null_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL null_cnt_three: got %0d expected 3", null_cnt);
    end
    n_checks++;
    if (rd_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_no_pop: got rd_req seen=%b expected 0", rd_seen);
    end
  endtask

  task automatic test_pass_two();
    int j, k;
    logic [7:0] exp;
    do_reset();
    put_pkt(8'h00, PKT_LEN);
    put_pkt(8'h80, PKT_LEN);
    wr_ptr = ld;
    release_reset();
    for (int c = 2; c < 2 + 3 * PKT_LEN; c++) begin
      @(negedge clk);
      j = (c - 2) / PKT_LEN;
      k = (c - 2) % PKT_LEN;
      exp = (j == 0) ? pkt_byte(8'h00, k) : (j == 1) ? pkt_byte(8'h80, k) : exp_null(k);
      n_checks++;
      if (data_out !== exp || p_sync_out !== (k == 0)) begin
        n_fail++;
        $display("FAIL pass_stream c=%0d: got data=%h sync=%b expected data=%h sync=%b",
                 c, data_out, p_sync_out, exp, (k == 0));
      end
      n_checks++;
      if (rd_req !== (c - 1 < 2 * PKT_LEN)) begin
        n_fail++;
        $display("FAIL pass_rd_req c=%0d: got %b expected %b", c, rd_req, (c - 1 < 2 * PKT_LEN));
      end
      if (c == 1 + 2 * PKT_LEN) begin
        n_checks++;
        if (null_cnt !== 16'd0) begin
          n_fail++;
          $display("FAIL pass_null_cnt_during: got %0d expected 0", null_cnt);
        end
      end
    end
    n_checks++;
    if (null_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL pass_null_cnt_after: got %0d expected 1", null_cnt);
    end
  endtask

  task automatic test_stray();
    int j, k;
    logic [7:0] exp;
    do_reset();
    put_stray(5);
    put_pkt(8'h20, PKT_LEN);
    wr_ptr = ld;
    release_reset();
    for (int c = 2; c < 2 + 3 * PKT_LEN; c++) begin
      @(negedge clk);
      j = (c - 2) / PKT_LEN;
      k = (c - 2) % PKT_LEN;
      exp = (j == 1) ? pkt_byte(8'h20, k) : exp_null(k);
      n_checks++;
      if (data_out !== exp || p_sync_out !== (k == 0)) begin
        n_fail++;
        $display("FAIL stray_stream c=%0d: got data=%h sync=%b expected data=%h sync=%b",
                 c, data_out, p_sync_out, exp, (k == 0));
      end
      if (c == 1 + PKT_LEN) begin
        n_checks++;
        if (drop_cnt !== 16'd5) begin
          n_fail++;
          $display("FAIL stray_drop_cnt: got %0d expected 5", drop_cnt);
        end
      end
    end
    n_checks++;
    if (null_cnt !== 16'd2 || drop_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL stray_counters_end: got null=%0d drop=%0d expected null=2 drop=5", null_cnt, drop_cnt);
    end
  endtask

  task automatic test_late_byte();
    int j, k;
    logic [7:0] exp;
    do_reset();
    put_pkt(8'h30, PKT_LEN);
    wr_ptr = PKT_LEN - 1;
    release_reset();
    for (int c = 2; c < 2 + 3 * PKT_LEN; c++) begin
      @(negedge clk);
      j = (c - 2) / PKT_LEN;
      k = (c - 2) % PKT_LEN;
      exp = (j == 1) ? pkt_byte(8'h30, k) : exp_null(k);
      n_checks++;
      if (data_out !== exp || p_sync_out !== (k == 0)) begin
        n_fail++;
        $display("FAIL late_stream c=%0d: got data=%h sync=%b expected data=%h sync=%b",
                 c, data_out, p_sync_out, exp, (k == 0));
      end
      if (c == 51) wr_ptr = ld;
    end
    n_checks++;
    if (drop_cnt !== 16'd0 || null_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL late_counters: got null=%0d drop=%0d expected null=2 drop=0", null_cnt, drop_cnt);
    end
  endtask

  task automatic test_underflow();
    int j, k, n_uf;
    logic [7:0] exp;
    do_reset();
    put_pkt(8'h40, PKT_LEN);
    put_pkt(8'h90, PKT_LEN);
    wr_ptr = ld;
    release_reset();
    n_uf = 0;
    for (int c = 2; c < 2 + 3 * PKT_LEN; c++) begin
      @(negedge clk);
      j = (c - 2) / PKT_LEN;
      k = (c - 2) % PKT_LEN;
      if (j == 0)      exp = (k < 100) ? pkt_byte(8'h40, k) : 8'hFF;
      else if (j == 1) exp = exp_null(k);
      else             exp = pkt_byte(8'h90, k);
      n_checks++;
      if (data_out !== exp || p_sync_out !== (k == 0)) begin
        n_fail++;
        $display("FAIL uflow_stream c=%0d: got data=%h sync=%b expected data=%h sync=%b",
                 c, data_out, p_sync_out, exp, (k == 0));
      end
      if (uflow) n_uf++;
      if (c == 102) begin
        n_checks++;
        if (uflow !== 1'b1) begin
          n_fail++;
          $display("FAIL uflow_pulse_time: got %b expected 1", uflow);
        end
      end
      if (c == 101) hold = 1'b1;
      if (c == 151) hold = 1'b0;
    end
    n_checks++;
    if (n_uf !== 1) begin
      n_fail++;
      $display("FAIL uflow_pulse_count: got %0d expected 1", n_uf);
    end
    n_checks++;
    if (drop_cnt !== 16'd88 || null_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL uflow_counters: got null=%0d drop=%0d expected null=1 drop=88", null_cnt, drop_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    release_reset();
    for (int c = 2; c < 2 + 2 * PKT_LEN + 2; c++) begin
      @(negedge clk);
      if (c == 3) dut.null_cnt = 16'hFFFE;
      if (c == 1 + PKT_LEN) begin
        n_checks++;
        if (null_cnt !== 16'hFFFE) begin
          n_fail++;
          $display("FAIL sat_before: got %h expected FFFE", null_cnt);
        end
      end
      if (c == 2 + PKT_LEN || c == 3 + 2 * PKT_LEN) begin
        n_checks++;
        if (null_cnt !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL sat_hold c=%0d: got %h expected FFFF", c, null_cnt);
        end
      end
    end
  endtask

  task automatic test_reset_mid_pass();
    int k;
    do_reset();
    put_pkt(8'h50, PKT_LEN);
    put_pkt(8'h60, PKT_LEN);
    wr_ptr = ld;
    release_reset();
    for (int c = 2; c < 52; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({data_out, d_valid_out, p_sync_out, uflow, rd_req, null_cnt, drop_cnt} !== 45'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got data=%h valid=%b sync=%b uflow=%b rd=%b null=%h drop=%h expected all 0",
               data_out, d_valid_out, p_sync_out, uflow, rd_req, null_cnt, drop_cnt);
    end
    repeat (2) @(negedge clk);
    release_reset();
    for (int c = 2; c < 2 + PKT_LEN; c++) begin
      @(negedge clk);
      k = c - 2;
      n_checks++;
      if (data_out !== pkt_byte(8'h50, k) || p_sync_out !== (k == 0) || d_valid_out !== 1'b1) begin
        n_fail++;
        $display("FAIL restart_stream c=%0d: got data=%h sync=%b valid=%b expected data=%h sync=%b valid=1",
                 c, data_out, p_sync_out, d_valid_out, pkt_byte(8'h50, k), (k == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty_nulls();
    test_pass_two();
    test_stray();
    test_late_byte();
    test_underflow();
    test_saturation();
    test_reset_mid_pass();
    n_checks++;
    if (bad_pop !== 0) begin
      n_fail++;
      $display("FAIL pop_while_empty: got %0d pops expected 0", bad_pop);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
